control_fsm: RTL and testbench

Multi-cycle controller that drives every control input of dataPath. Fetches an instruction from memory port A, decodes it, and sequences regwrite/wa/aluop/memory-mux/PC controls. Holds the instruction register and a latched copy of the ALU flags for conditional jumps. Sits beside dataPath in the processor top; dataPath outputs (q_a, flags_alu) feed back into it.

---
 rtl/cpu_ctrl_pkg.sv | 87 ++++++++
 rtl/cond_eval.sv | 31 +++
 rtl/control_fsm.sv | 176 +++++++++++++++++
 tb/tb_control_fsm.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared state encodings, instruction fields and control-word type for the CPU controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_ctrl_pkg;

    // Controller states; the numeric values are visible on the debug state port.
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_LD_ADDR = 3'd3,
        ST_LD_WB   = 3'd4,
        ST_STORE   = 3'd5
    } state_t;

    // Opcode field IR[15:12]
    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;

    // Opcode-extension field IR[7:4]
    localparam logic [3:0] EXT_ADDC  = 4'b0111;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // Jump condition codes (carried in the Rdest field of a Jcond)
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    // Bit positions inside the 5-bit flag vector {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Instruction classes after decode
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_CMP,
        CLS_LOAD,
        CLS_STOR,
        CLS_JCOND,
        CLS_NOP
    } iclass_t;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic       regwrite;
        logic [3:0] wa;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [7:0] aluop;
        logic       cin;
        logic       we_a;
        logic       we_b;
        logic       ld_mux_en_a;
        logic       ld_mux_en_b;
        logic       pc_en;
        logic       ld_pc_en;
        logic       pc_mux;
    } ctrl_t;

    // Classify an instruction word; anything not recognised is a NOP.
    function automatic iclass_t classify(input logic [3:0] opcode, input logic [3:0] opext);
        iclass_t cls;
        cls = CLS_NOP;
        if (opcode == OP_RTYPE) begin
            cls = (opext == EXT_CMP) ? CLS_CMP : CLS_ALU;
        end else if (opcode == OP_MEM) begin
            case (opext)
                EXT_LOAD:  cls = CLS_LOAD;
                EXT_STOR:  cls = CLS_STOR;
                EXT_JCOND: cls = CLS_JCOND;
                default:   cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Purpose: evaluate a Jcond condition code against a flag vector.
// Latency: combinational.
// Backpressure: none.
// Ports: cond (4-bit condition code), flags ({C,L,F,Z,N}), taken (1 = jump).
module cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    // L and F never participate in any jump condition.
    logic unused_flags;
    assign unused_flags = flags[FLAG_L] ^ flags[FLAG_F];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = ~flags[FLAG_Z];
            COND_CS: taken = flags[FLAG_C];
            COND_CC: taken = ~flags[FLAG_C];
            COND_LT: taken = flags[FLAG_N];
            COND_GE: taken = ~flags[FLAG_N];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Purpose: multi-cycle fetch/decode/execute controller driving every dataPath control input.
// Latency: 3 cycles per instruction (R-type, CMP, Jcond, STOR, NOP), 4 cycles for LOAD.
// Backpressure: none; memory is assumed to return q_a one cycle after the PC address is presented.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   q_a, flags_alu    - instruction word from memory port A, ALU flags {C,L,F,Z,N}
//   regwrite, wa      - register-file write enable / address
//   ra1, ra2, aluop   - register read addresses and ALU operation, straight from IR
//   Cin               - ALU carry-in (latched C for ADDC in EXEC)
//   we_a, we_b        - memory write enables (port A is read-only, so we_a is always 0)
//   LD_mux_en_a/b     - load write-back mux and port-B address mux
//   pc_en, ld_pc_en, pc_mux - PC update, PC-to-port-A select, PC+1 vs jump-target select
//   state             - current FSM state, debug only
module control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] q_a,
    input  logic [4:0]  flags_alu,
    output logic        regwrite,
    output logic [3:0]  wa,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [7:0]  aluop,
    output logic        Cin,
    output logic        we_a,
    output logic        we_b,
    output logic        LD_mux_en_a,
    output logic        LD_mux_en_b,
    output logic        pc_en,
    output logic        ld_pc_en,
    output logic        pc_mux,
    output logic [2:0]  state
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  flags_q, flags_d;
    ctrl_t       ctrl_q;
    logic        taken_d;
    iclass_t     exec_cls;

    assign exec_cls = classify(ir_q[15:12], ir_q[7:4]);

    // Condition is evaluated on the values the registers will hold next
    // cycle, so the registered control word is already correct in EXEC.
    cond_eval u_cond_eval (
        .cond  (ir_d[11:8]),
        .flags (flags_d),
        .taken (taken_d)
    );

    // Control word for a given (state, IR, latched flags). Outputs are a
    // pure Moore function of these; they are registered by evaluating this
    // on the next-state values.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir,
                                          input logic c_flag, input logic taken);
        ctrl_t   c;
        iclass_t cls;
        cls           = classify(ir[15:12], ir[7:4]);
        c             = '0;
        c.wa          = ir[11:8];
        c.ra1         = ir[11:8];
        c.ra2         = ir[3:0];
        c.aluop       = {ir[15:12], ir[7:4]};
        case (st)
            ST_FETCH: begin
                c.ld_pc_en = 1'b1;
            end
            ST_DECODE: begin
                c.pc_en  = 1'b1;
                c.pc_mux = 1'b0;
            end
            ST_EXEC: begin
                if (cls == CLS_ALU) begin
                    c.regwrite = 1'b1;
                    // Only add-with-carry consumes the latched carry.
                    c.cin      = (ir[7:4] == EXT_ADDC) ? c_flag : 1'b0;
                end
                if (cls == CLS_JCOND && taken) begin
                    c.pc_en  = 1'b1;
                    c.pc_mux = 1'b1;
                end
            end
            ST_LD_ADDR: begin
                c.ld_mux_en_b = 1'b1;
            end
            ST_LD_WB: begin
                c.ld_mux_en_b = 1'b1;
                c.ld_mux_en_a = 1'b1;
                c.regwrite    = 1'b1;
            end
            ST_STORE: begin
                c.ld_mux_en_b = 1'b1;
                c.we_b        = 1'b1;
            end
            default: begin
                c.ld_pc_en = 1'b0;
            end
        endcase
        return c;
    endfunction

    // Next-state, IR and flag-register update. q_a is only looked at in
    // DECODE, one cycle after FETCH presented the PC on port A.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = q_a;
                case (classify(q_a[15:12], q_a[7:4]))
                    CLS_LOAD: state_d = ST_LD_ADDR;
                    CLS_STOR: state_d = ST_STORE;
                    default:  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                // CMP exists only to set flags, so it latches them too.
                if (exec_cls == CLS_ALU || exec_cls == CLS_CMP) begin
                    flags_d = flags_alu;
                end
                state_d = ST_FETCH;
            end
            ST_LD_ADDR: begin
                state_d = ST_LD_WB;
            end
            ST_LD_WB: begin
                state_d = ST_FETCH;
            end
            ST_STORE: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            ir_q    <= '0;
            flags_q <= '0;
            ctrl_q  <= decode_ctrl(state_t'(RESET_STATE), 16'h0000, 1'b0, 1'b0);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            ctrl_q  <= decode_ctrl(state_d, ir_d, flags_d[FLAG_C], taken_d);
        end
    end

    assign regwrite    = ctrl_q.regwrite;
    assign wa          = ctrl_q.wa;
    assign ra1         = ctrl_q.ra1;
    assign ra2         = ctrl_q.ra2;
    assign aluop       = ctrl_q.aluop;
    assign Cin         = ctrl_q.cin;
    assign we_a        = ctrl_q.we_a;
    assign we_b        = ctrl_q.we_b;
    assign LD_mux_en_a = ctrl_q.ld_mux_en_a;
    assign LD_mux_en_b = ctrl_q.ld_mux_en_b;
    assign pc_en       = ctrl_q.pc_en;
    assign ld_pc_en    = ctrl_q.ld_pc_en;
    assign pc_mux      = ctrl_q.pc_mux;
    assign state       = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Purpose: self-checking bench for control_fsm against an instruction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] q_a;
    logic [4:0]  flags_alu;
    logic        regwrite, Cin, we_a, we_b, LD_mux_en_a, LD_mux_en_b;
    logic        pc_en, ld_pc_en, pc_mux;
    logic [3:0]  wa, ra1, ra2;
    logic [7:0]  aluop;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural view only (instruction register and
    // latched flags), updated once per instruction.
    logic [15:0] m_ir;
    logic [4:0]  m_flags;

    control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .q_a         (q_a),
        .flags_alu   (flags_alu),
        .regwrite    (regwrite),
        .wa          (wa),
        .ra1         (ra1),
        .ra2         (ra2),
        .aluop       (aluop),
        .Cin         (Cin),
        .we_a        (we_a),
        .we_b        (we_b),
        .LD_mux_en_a (LD_mux_en_a),
        .LD_mux_en_b (LD_mux_en_b),
        .pc_en       (pc_en),
        .ld_pc_en    (ld_pc_en),
        .pc_mux      (pc_mux),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Flags are {C,L,F,Z,N}.
    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
        case (c)
            4'd0:    return f[1];
            4'd1:    return !f[1];
            4'd2:    return f[4];
            4'd3:    return !f[4];
            4'd12:   return f[0];
            4'd13:   return !f[0];
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison of every DUT output against expectation; register
    // fields always reflect the model's current instruction register.
    task automatic check(input string tag, input logic [2:0] st, input logic rw,
                         input logic cin, input logic wb, input logic lda,
                         input logic ldb, input logic pce, input logic ldpc,
                         input logic pcm);
        logic [31:0] exp_v, obs_v;
        exp_v = {st, rw, m_ir[11:8], m_ir[11:8], m_ir[3:0], m_ir[15:12], m_ir[7:4],
                 cin, 1'b0, wb, lda, ldb, pce, ldpc, pcm};
        obs_v = {state, regwrite, wa, ra1, ra2, aluop,
                 Cin, we_a, we_b, LD_mux_en_a, LD_mux_en_b, pc_en, ld_pc_en, pc_mux};
        tests++;
        assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs_v, exp_v);
        end
    endtask

    // Runs one instruction from FETCH back to (but not including) the next FETCH.
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] fa, input string tag);
        logic [3:0] opc, ext;
        logic is_r, is_cmp, is_load, is_stor, is_j, tk;
        opc     = ins[15:12];
        ext     = ins[7:4];
        is_r    = (opc == 4'h0);
        is_cmp  = is_r && (ext == 4'hB);
        is_load = (opc == 4'h4) && (ext == 4'h0);
        is_stor = (opc == 4'h4) && (ext == 4'h4);
        is_j    = (opc == 4'h4) && (ext == 4'hC);

        check({tag, "/fetch"}, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        q_a       = ins;
        flags_alu = fa;
        step();
        check({tag, "/decode"}, 3'd1, 0, 0, 0, 0, 0, 1, 0, 0);
        m_ir = ins;
        step();
        if (is_load) begin
            check({tag, "/ld_addr"}, 3'd3, 0, 0, 0, 0, 1, 0, 0, 0);
            step();
            check({tag, "/ld_wb"}, 3'd4, 1, 0, 0, 1, 1, 0, 0, 0);
            step();
        end else if (is_stor) begin
            check({tag, "/store"}, 3'd5, 0, 0, 1, 0, 1, 0, 0, 0);
            step();
        end else begin
            tk = is_j && cond_true(ins[11:8], m_flags);
            check({tag, "/exec"}, 3'd2, is_r && !is_cmp,
                  (is_r && !is_cmp && ext == 4'h7) ? m_flags[4] : 1'b0,
                  0, 0, 0, tk, 0, tk);
            if (is_r) m_flags = fa;
            step();
        end
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  r1, r2, r3;
        reset     = 1'b1;
        q_a       = 16'h0000;
        flags_alu = 5'b00000;
        m_ir      = 16'h0000;
        m_flags   = 5'b00000;
        step();
        step();
        reset = 1'b0;
        check("reset", 3'd0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Directed sequence
        run_instr(16'h0152, 5'b00000, "add");
        run_instr(16'h03B4, 5'b00010, "cmp_z");
        run_instr(16'h40C5, 5'b11111, "jeq_taken");
        run_instr(16'h41C5, 5'b00000, "jne_not");
        run_instr(16'h47C3, 5'b00000, "j0111_never");
        run_instr(16'h4EC9, 5'b00000, "juc");
        run_instr(16'h4706, 5'b10101, "load");
        run_instr(16'h4248, 5'b01010, "stor");
        run_instr(16'h01B2, 5'b10000, "cmp_c");
        run_instr(16'h0172, 5'b00001, "addc_cin1");
        run_instr(16'h0172, 5'b00000, "addc_cin0");
        run_instr(16'hF0F0, 5'b11111, "nop");
        run_instr(16'h42C1, 5'b00000, "jcs_not");

        // Set flags, then reset in the middle of a LOAD (2 cycles).
        run_instr(16'h05B6, 5'b10011, "cmp_pre_rst");
        check("pre_rst_fetch", 3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        q_a = 16'h4906;
        step();
        check("rst_load/decode", 3'd1, 0, 0, 0, 0, 0, 1, 0, 0);
        m_ir = 16'h4906;
        step();
        check("rst_load/ld_addr", 3'd3, 0, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        step();
        step();
        reset   = 1'b0;
        m_ir    = 16'h0000;
        m_flags = 5'b00000;
        check("rst_mid_load", 3'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_instr(16'h41C3, 5'b00000, "jne_after_rst");
        run_instr(16'h40C3, 5'b00000, "jeq_after_rst");

        // Randomized instruction mix
        for (int n = 0; n < 300; n++) begin
            r1 = 4'($urandom);
            r2 = 4'($urandom);
            r3 = 4'($urandom);
            case ($urandom_range(0, 6))
                0:       ins = {4'h0, r1, r2, r3};
                1:       ins = {4'h0, r1, 4'hB, r3};
                2:       ins = {4'h0, r1, 4'h7, r3};
                3:       ins = {4'h4, r1, 4'h0, r3};
                4:       ins = {4'h4, r1, 4'h4, r3};
                5:       ins = {4'h4, r1, 4'hC, r3};
                default: ins = 16'($urandom);
            endcase
            run_instr(ins, 5'($urandom), "rand");
        end
        check("final_fetch", 3'd0, 0, 0, 0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
